// File: rtl/grf_wb_sched_pkg.sv
// Shared types and constants for the GRF write-back scheduler.
// Holds the buffer FSM encoding, the default starvation limit and register-index sizing.
package grf_wb_sched_pkg;

  localparam int STARVE_MAX_DEFAULT = 3;
  localparam int REG_IDX_W          = 5;
  localparam int NUM_REGS           = 1 << REG_IDX_W;
  localparam int XLEN               = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HELD  = 2'd1,
    ST_DRAIN = 2'd2
  } wb_state_e;

  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_IDX_W-1:0] idx);
    reg_onehot      = '0;
    reg_onehot[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/wb_buffer.sv
// One-entry capture register for an MDU result waiting for the GRF write port.
// Capture has priority over clear; the data fields stay stale once the entry is drained.
module wb_buffer
  import grf_wb_sched_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 capture_i,
  input  logic                 clear_i,
  input  logic [REG_IDX_W-1:0] wa_i,
  input  logic [XLEN-1:0]      wd_i,
  input  logic [XLEN-1:0]      pc_i,
  output logic                 full_o,
  output logic [REG_IDX_W-1:0] wa_o,
  output logic [XLEN-1:0]      wd_o,
  output logic [XLEN-1:0]      pc_o
);

  logic                 full_q;
  logic [REG_IDX_W-1:0] wa_q;
  logic [XLEN-1:0]      wd_q;
  logic [XLEN-1:0]      pc_q;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      full_q <= 1'b0;
      wa_q   <= '0;
      wd_q   <= '0;
      pc_q   <= '0;
    end else if (capture_i) begin
      full_q <= 1'b1;
      wa_q   <= wa_i;
      wd_q   <= wd_i;
      pc_q   <= pc_i;
    end else if (clear_i) begin
      full_q <= 1'b0;
    end
  end

  assign full_o = full_q;
  assign wa_o   = wa_q;
  assign wd_o   = wd_q;
  assign pc_o   = pc_q;

endmodule

// File: rtl/grf_wb_sched.sv
// Arbitrates the single GRF write port between the W stage and a buffered MDU result,
// and keeps the long-op pending scoreboard that drives the D-stage hazard stall.
module grf_wb_sched
  import grf_wb_sched_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  input  logic                 W_WE,
  input  logic [REG_IDX_W-1:0] W_WA,
  input  logic [XLEN-1:0]      W_WD,
  input  logic [XLEN-1:0]      W_PC,
  input  logic                 Md_Req,
  input  logic [REG_IDX_W-1:0] Md_WA,
  input  logic [XLEN-1:0]      Md_WD,
  input  logic [XLEN-1:0]      Md_PC,
  output logic                 Md_Ack,
  input  logic                 Issue_Valid,
  input  logic                 Issue_Long,
  input  logic [REG_IDX_W-1:0] Issue_A1,
  input  logic [REG_IDX_W-1:0] Issue_A2,
  input  logic [REG_IDX_W-1:0] Issue_WA,
  output logic                 Stall,
  output logic                 Hold_W,
  output logic                 Busy,
  output logic                 GRF_WE,
  output logic [REG_IDX_W-1:0] GRF_WA,
  output logic [XLEN-1:0]      GRF_WD,
  output logic [XLEN-1:0]      GRF_PC
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  wb_state_e            state_q, state_d;
  logic [CNT_W-1:0]     starve_q, starve_d;
  logic                 hold_w_q;
  logic                 busy_q, busy_d;
  logic [NUM_REGS-1:0]  pending_q, pending_d, pending_vis, drain_mask, set_mask;

  logic                 buf_full;
  logic [REG_IDX_W-1:0] buf_wa;
  logic [XLEN-1:0]      buf_wd, buf_pc;
  logic                 w_wins, drain, capture, discard, md_ack;
  logic                 stall_raw, accept_long;
  logic                 grf_we;
  logic [REG_IDX_W-1:0] grf_wa;
  logic [XLEN-1:0]      grf_wd, grf_pc;

  wb_buffer u_wb_buffer (
    .clk_i     (Clk),
    .rst_ni    (Reset_n),
    .capture_i (capture),
    .clear_i   (drain),
    .wa_i      (Md_WA),
    .wd_i      (Md_WD),
    .pc_i      (Md_PC),
    .full_o    (buf_full),
    .wa_o      (buf_wa),
    .wd_o      (buf_wd),
    .pc_o      (buf_pc)
  );

  assign w_wins = W_WE & (W_WA != '0);
  assign drain  = buf_full & ~w_wins;

  // NOTE: every variable written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    md_ack   = 1'b0;
    capture  = 1'b0;
    discard  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        starve_d = '0;
        if (Md_Req) begin
          md_ack = 1'b1;
          if (Md_WA != '0) begin
            capture = 1'b1;
            state_d = ST_HELD;
          end else begin
            discard = 1'b1;
          end
        end
      end
      ST_HELD: begin
        if (drain) begin
          state_d  = ST_IDLE;
          starve_d = '0;
        end else begin
          starve_d = starve_q + 1'b1;
          if (starve_d == CNT_W'(STARVE_MAX)) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (drain) begin
          state_d  = ST_IDLE;
          starve_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    grf_we = 1'b0;
    grf_wa = '0;
    grf_wd = '0;
    grf_pc = '0;
    if (w_wins) begin
      grf_we = 1'b1;
      grf_wa = W_WA;
      grf_wd = W_WD;
      grf_pc = W_PC;
    end else if (buf_full) begin
      grf_we = 1'b1;
      grf_wa = buf_wa;
      grf_wd = buf_wd;
      grf_pc = buf_pc;
    end
  end

  // A drain this cycle already lands in the GRF, so its pending bit no longer blocks readers.
  assign drain_mask  = drain ? reg_onehot(buf_wa) : '0;
  assign pending_vis = pending_q & ~drain_mask;
  assign stall_raw   = Issue_Valid & (pending_vis[Issue_A1] | pending_vis[Issue_A2] |
                                      pending_vis[Issue_WA] | (Issue_Long & busy_q));
  assign accept_long = Issue_Valid & Issue_Long & ~stall_raw;
  assign set_mask    = (accept_long && Issue_WA != '0) ? reg_onehot(Issue_WA) : '0;
  assign pending_d   = {pending_vis[NUM_REGS-1:1] | set_mask[NUM_REGS-1:1], 1'b0};

  always_comb begin
    busy_d = busy_q;
    if (accept_long)          busy_d = 1'b1;
    else if (drain | discard) busy_d = 1'b0;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= ST_IDLE;
      starve_q  <= '0;
      hold_w_q  <= 1'b0;
      busy_q    <= 1'b0;
      // NOTE: the scoreboard is reset; a stale pending bit would stall its register forever.
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      starve_q  <= starve_d;
      hold_w_q  <= (state_d == ST_DRAIN);
      busy_q    <= busy_d;
      pending_q <= pending_d;
    end
  end

  // Combinational outputs are forced quiet while reset is asserted, whatever the inputs do.
  assign Md_Ack = Reset_n & md_ack;
  assign Stall  = Reset_n & stall_raw;
  assign GRF_WE = Reset_n & grf_we;
  assign GRF_WA = Reset_n ? grf_wa : '0;
  assign GRF_WD = Reset_n ? grf_wd : '0;
  assign GRF_PC = Reset_n ? grf_pc : '0;
  assign Hold_W = hold_w_q;
  assign Busy   = busy_q;

endmodule

// File: tb/tb_grf_wb_sched.sv
// Self-checking bench for grf_wb_sched: directed scenarios, then randomized traffic,
// all compared every cycle against a behavioural model of the write-back rules.
module tb_grf_wb_sched;

  localparam int STARVE_MAX = 3;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        W_WE, Md_Req, Md_Ack, Issue_Valid, Issue_Long, Stall, Hold_W, Busy, GRF_WE;
  logic [4:0]  W_WA, Md_WA, Issue_A1, Issue_A2, Issue_WA, GRF_WA;
  logic [31:0] W_WD, W_PC, Md_WD, Md_PC, GRF_WD, GRF_PC;

  always #5 Clk = ~Clk;

  grf_wb_sched #(.STARVE_MAX(STARVE_MAX)) dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .W_WE(W_WE), .W_WA(W_WA), .W_WD(W_WD), .W_PC(W_PC),
    .Md_Req(Md_Req), .Md_WA(Md_WA), .Md_WD(Md_WD), .Md_PC(Md_PC), .Md_Ack(Md_Ack),
    .Issue_Valid(Issue_Valid), .Issue_Long(Issue_Long),
    .Issue_A1(Issue_A1), .Issue_A2(Issue_A2), .Issue_WA(Issue_WA),
    .Stall(Stall), .Hold_W(Hold_W), .Busy(Busy),
    .GRF_WE(GRF_WE), .GRF_WA(GRF_WA), .GRF_WD(GRF_WD), .GRF_PC(GRF_PC)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: an optional waiting result, a lost-cycle count, a set of pending registers.
  bit          m_full, m_hold, m_busy;
  logic [4:0]  m_wa;
  logic [31:0] m_wd, m_pc;
  int          m_lost;
  bit [31:0]   m_pend;

  logic        s_we, s_ack, s_stall, s_hold, s_busy;
  logic [4:0]  s_wa;
  logic [31:0] s_wd;
  bit          last_ack, acc_long;
  logic [4:0]  acc_wa;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    W_WE = 0; W_WA = 0; W_WD = 0; W_PC = 0;
    Md_Req = 0; Md_WA = 0; Md_WD = 0; Md_PC = 0;
    Issue_Valid = 0; Issue_Long = 0; Issue_A1 = 0; Issue_A2 = 0; Issue_WA = 0;
  endtask

  task automatic model_reset();
    m_full = 0; m_hold = 0; m_busy = 0; m_lost = 0; m_pend = '0;
    m_wa = 0; m_wd = 0; m_pc = 0;
  endtask

  // Entered at posedge+1 with inputs set; checks at negedge, advances the model at posedge.
  task automatic cycle();
    bit          w_wins, drain, e_we, e_ack, e_stall;
    logic [4:0]  e_wa;
    logic [31:0] e_wd, e_pc;
    bit   [31:0] pv;
    @(negedge Clk);
    w_wins  = W_WE && (W_WA != 0);
    drain   = m_full && !w_wins;
    e_we    = w_wins || m_full;
    e_wa    = w_wins ? W_WA : (m_full ? m_wa : 5'd0);
    e_wd    = w_wins ? W_WD : (m_full ? m_wd : 32'd0);
    e_pc    = w_wins ? W_PC : (m_full ? m_pc : 32'd0);
    e_ack   = !m_full && Md_Req;
    pv      = m_pend;
    if (drain) pv[m_wa] = 1'b0;
    e_stall = Issue_Valid && (pv[Issue_A1] || pv[Issue_A2] || pv[Issue_WA] ||
                              (Issue_Long && m_busy));
    s_we = GRF_WE; s_wa = GRF_WA; s_wd = GRF_WD;
    s_ack = Md_Ack; s_stall = Stall; s_hold = Hold_W; s_busy = Busy;
    check("grf_we", GRF_WE, e_we);
    check("grf_wa", GRF_WA, e_wa);
    check("grf_wd", GRF_WD, e_wd);
    check("grf_pc", GRF_PC, e_pc);
    check("md_ack", Md_Ack, e_ack);
    check("stall",  Stall,  e_stall);
    check("hold_w", Hold_W, m_hold);
    check("busy",   Busy,   m_busy);
    @(posedge Clk);
    last_ack = e_ack;
    acc_long = Issue_Valid && Issue_Long && !e_stall;
    acc_wa   = Issue_WA;
    if (drain) begin
      m_pend[m_wa] = 1'b0;
      m_full = 0; m_lost = 0; m_hold = 0; m_busy = 0;
    end else if (m_full && !m_hold) begin
      m_lost++;
      if (m_lost >= STARVE_MAX) m_hold = 1;
    end
    if (e_ack) begin
      if (Md_WA != 0) begin
        m_full = 1; m_wa = Md_WA; m_wd = Md_WD; m_pc = Md_PC; m_lost = 0;
      end else begin
        m_busy = 0;
      end
    end
    if (acc_long) begin
      m_busy = 1;
      if (Issue_WA != 0) m_pend[Issue_WA] = 1'b1;
    end
    #1;
  endtask

  task automatic apply_reset(input int hold_cycles);
    Reset_n = 1'b0;
    model_reset();
    #1;
    check("rst_grf_we", GRF_WE, 0);
    check("rst_grf_wd", GRF_WD, 0);
    check("rst_md_ack", Md_Ack, 0);
    check("rst_stall",  Stall,  0);
    check("rst_hold_w", Hold_W, 0);
    check("rst_busy",   Busy,   0);
    clear_inputs();
    repeat (hold_cycles) @(posedge Clk);
    #1;
    Reset_n = 1'b1;
  endtask

  task automatic long_issue(input logic [4:0] wa);
    Issue_Valid = 1; Issue_Long = 1; Issue_WA = wa;
    cycle();
    Issue_Valid = 0; Issue_Long = 0; Issue_WA = 0;
  endtask

  task automatic md_send(input logic [4:0] wa, input logic [31:0] wd, input logic [31:0] pc);
    Md_Req = 1; Md_WA = wa; Md_WD = wd; Md_PC = pc;
    cycle();
    check("md_handshake_ack", s_ack, 1);
    Md_Req = 0; Md_WA = 0; Md_WD = 0; Md_PC = 0;
  endtask

  bit         mdu_wait;
  int         mdu_delay;
  logic [4:0] mdu_wa;

  initial begin
    clear_inputs();
    Reset_n = 1'b0;
    apply_reset(2);

    // Free-port drain one cycle after the handshake.
    long_issue(5'd5);
    md_send(5'd5, 32'h1234, 32'h3000);
    cycle();
    check("drain_we", s_we, 1);
    check("drain_wa", s_wa, 5);
    check("drain_wd", s_wd, 32'h1234);
    Issue_Valid = 1; Issue_A1 = 5;
    cycle();
    check("pend5_cleared", s_stall, 0);
    check("busy_after_drain", s_busy, 0);
    Issue_Valid = 0; Issue_A1 = 0;

    // Starvation: three lost cycles force Hold_W for one drain cycle.
    long_issue(5'd12);
    md_send(5'd12, 32'hBEEF, 32'h3004);
    W_WE = 1; W_WA = 7; W_WD = 32'h1111; W_PC = 32'h5000;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("starve_w_wins", s_wa, 7);
      check("starve_hold_low", s_hold, 0);
    end
    W_WE = 0; W_WA = 0;
    cycle();
    check("starve_hold_high", s_hold, 1);
    check("starve_drain_wd", s_wd, 32'hBEEF);
    cycle();
    check("starve_hold_released", s_hold, 0);
    check("starve_idle_we", s_we, 0);

    // W ignores Hold_W once: W still wins and the buffer waits another cycle.
    long_issue(5'd13);
    md_send(5'd13, 32'hCAFE, 32'h3008);
    W_WE = 1; W_WA = 7;
    repeat (4) cycle();
    check("drain_w_override_hold", s_hold, 1);
    check("drain_w_override_wa", s_wa, 7);
    W_WE = 0; W_WA = 0;
    cycle();
    check("drain_late_wa", s_wa, 13);
    cycle();
    check("drain_late_hold_low", s_hold, 0);

    // RAW stall on WA 9 lifts in the drain cycle itself.
    long_issue(5'd9);
    Issue_Valid = 1; Issue_A1 = 9;
    repeat (2) cycle();
    check("raw_stall_pending", s_stall, 1);
    Md_Req = 1; Md_WA = 9; Md_WD = 32'h9999; Md_PC = 32'h300C;
    cycle();
    check("raw_stall_at_ack", s_stall, 1);
    Md_Req = 0; Md_WA = 0;
    W_WE = 1; W_WA = 3;
    cycle();
    check("raw_stall_held", s_stall, 1);
    W_WE = 0; W_WA = 0;
    cycle();
    check("raw_drain_wa", s_wa, 9);
    check("raw_stall_drop", s_stall, 0);
    Issue_Valid = 0; Issue_A1 = 0;

    // Second long issue while Busy is refused and leaves the scoreboard alone.
    long_issue(5'd10);
    Issue_Valid = 1; Issue_Long = 1; Issue_WA = 11;
    cycle();
    check("busy_second_long_stall", s_stall, 1);
    Issue_Long = 0; Issue_WA = 0; Issue_A1 = 11;
    cycle();
    check("busy_pend11_unset", s_stall, 0);
    Issue_A1 = 10;
    cycle();
    check("busy_pend10_kept", s_stall, 1);
    Issue_Valid = 0; Issue_A1 = 0;
    md_send(5'd10, 32'hA0A0, 32'h3010);
    cycle();

    // Result to r0 is acked and dropped.
    long_issue(5'd0);
    md_send(5'd0, 32'hDEAD, 32'h3014);
    check("r0_no_write", s_we, 0);
    check("r0_busy_before", s_busy, 1);
    cycle();
    check("r0_busy_cleared", s_busy, 0);
    check("r0_still_no_write", s_we, 0);

    // Reset mid-HELD with live inputs on every port.
    long_issue(5'd6);
    md_send(5'd6, 32'h6666, 32'h3018);
    W_WE = 1; W_WA = 2;
    cycle();
    Md_Req = 1; Md_WA = 6; Issue_Valid = 1; Issue_Long = 1; Issue_WA = 8;
    apply_reset(2);
    Issue_Valid = 1; Issue_A1 = 6;
    repeat (3) cycle();
    check("post_reset_no_we", s_we, 0);
    check("post_reset_no_stall", s_stall, 0);
    clear_inputs();
    cycle();

    // Randomized traffic with an MDU agent that obeys the handshake.
    mdu_wait = 0; mdu_delay = 0; mdu_wa = 0;
    for (int n = 0; n < 3000; n++) begin
      W_WE = m_hold ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 9) < 6);
      W_WA = 5'($urandom_range(0, 31));
      W_WD = $urandom;
      W_PC = $urandom;
      Issue_Valid = 1'($urandom_range(0, 1));
      Issue_Long  = ($urandom_range(0, 3) == 0);
      Issue_A1    = 5'($urandom_range(0, 15));
      Issue_A2    = 5'($urandom_range(0, 15));
      Issue_WA    = 5'($urandom_range(0, 15));
      if (!Md_Req && mdu_wait) begin
        if (mdu_delay == 0) begin
          Md_Req = 1; Md_WA = mdu_wa; Md_WD = $urandom; Md_PC = $urandom;
          mdu_wait = 0;
        end else begin
          mdu_delay--;
        end
      end
      cycle();
      if (Md_Req && last_ack) begin
        Md_Req = 0; Md_WA = 0; Md_WD = 0; Md_PC = 0;
      end
      if (acc_long) begin
        mdu_wait  = 1;
        mdu_wa    = acc_wa;
        mdu_delay = $urandom_range(0, 3);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/grf_wb_sched.md
GRF_WB_SCHED -- requirements
Module: grf_wb_sched

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 3: consecutive lost arbitration cycles before Hold_W is forced.
REQ-002 SHALL have ports Clk in 1 (clock) and Reset_n in 1 (reset); one clock, reset is asynchronous and active-low.
REQ-003 SHALL have W_WE in 1, W_WA in 5, W_WD in 32, W_PC in 32: W-stage write request, never back-pressured.
REQ-004 SHALL have Md_Req in 1, Md_WA in 5, Md_WD in 32, Md_PC in 32, Md_Ack out 1: MDU result handshake.
REQ-005 SHALL have Issue_Valid in 1, Issue_Long in 1, Issue_A1 in 5, Issue_A2 in 5, Issue_WA in 5: D-stage issue check.
REQ-006 SHALL have Stall out 1: D-stage hazard stall.
REQ-007 SHALL have Hold_W out 1: upstream inserts a W bubble.
REQ-008 SHALL have Busy out 1: one long op outstanding.
REQ-009 SHALL have GRF_WE out 1, GRF_WA out 5, GRF_WD out 32, GRF_PC out 32: the single GRF write port.

Function
REQ-010 SHALL hold state in a buffer FSM: IDLE (buffer empty), HELD (buffer full, waiting), DRAIN (buffer full, Hold_W=1).
REQ-011 SHALL drive GRF_* combinationally from the current cycle: W wins when W_WE=1 and W_WA!=0; otherwise a full buffer is written; otherwise GRF_WE=0.
REQ-012 SHALL give zero-cycle W-to-GRF latency; the buffer drains in the cycle the port is free.
REQ-013 SHALL, in IDLE with Md_Req=1, assert Md_Ack combinationally for exactly that cycle, capture WA/WD/PC on the edge, and go to HELD.
REQ-014 SHALL treat Md_WA=0 as acked and discarded: stay in IDLE and clear Busy.
REQ-015 SHALL hold Md_Ack=0 in HELD and DRAIN; the MDU keeps Md_Req and data stable until acked.
REQ-016 SHALL, in HELD, drain when the port is free and go to IDLE; otherwise increment starve_cnt, and go to DRAIN when starve_cnt reaches STARVE_MAX.
REQ-017 SHALL assert Hold_W registered, only in DRAIN.
REQ-018 SHALL, in DRAIN, write the buffer and go to IDLE; if W_WE=1 arrives anyway, W wins and the FSM stays in DRAIN.
REQ-019 SHALL zero starve_cnt on every entry to IDLE.
REQ-020 SHALL keep a 32-bit pending scoreboard; bit 0 is always 0.
REQ-021 SHALL set pending[Issue_WA] on Issue_Valid & Issue_Long & !Stall & Issue_WA!=0.
REQ-022 SHALL clear that bit on a buffer drain to the same WA; on a same-cycle set and clear, set wins.
REQ-023 SHALL compute Stall = Issue_Valid & (pending[A1] | pending[A2] | pending[WA] | (Issue_Long & Busy)), combinationally.
REQ-024 SHALL set Busy on accepted long issue and clear it on drain or discard.

Reset
REQ-025 SHALL, while Reset_n=0, asynchronously force FSM=IDLE, buffer=0, starve_cnt=0, pending=0, Busy=0, Hold_W=0.
REQ-026 SHALL drop any buffered result on reset mid-operation without writing it.
REQ-027 SHALL, in reset, have GRF_WE=0, Md_Ack=0 and Stall=0.
REQ-028 SHALL leave data outputs in reset as don't-care-free zeros.

Structure
REQ-029 SHALL place the FSM state encoding, STARVE_MAX default and register-index width in the shared header package.
REQ-030 SHALL instantiate one sub-module, wb_buffer: the one-entry capture register with full flag.
REQ-031 SHALL implement the scoreboard and arbitration inline.

Verification
REQ-032 SHALL cover free-port drain: Md_Req WA=5 WD=0x1234 with W idle -> Md_Ack cycle 0, GRF_WE/WA=5/WD=0x1234 cycle 1, pending[5] cleared.
REQ-033 SHALL cover starvation: buffer HELD while W_WE=1 WA=7 for 3 cycles -> Hold_W=1 next cycle, buffer written that cycle, Hold_W=0 after.
REQ-034 SHALL cover RAW stall: long issue WA=9, then Issue_A1=9 -> Stall=1 until drain of WA 9, then 0 in the same cycle.
REQ-035 SHALL cover a second long issue while Busy -> Stall=1; pending unchanged.
REQ-036 SHALL cover Md_WA=0 -> Md_Ack=1, no GRF write, Busy=0.
REQ-037 SHALL cover Reset_n low mid-HELD -> immediate IDLE, pending=0, no GRF_WE after release.
